// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, sigma functions and schedule types.
// The message-schedule expander and the round stage both import this package.
package sha256_pkg;

    typedef logic [31:0] sha_word_t;

    typedef enum logic {LOAD, RUN} sched_state_t;

    // First 32 bits of the fractional parts of the cube roots of the first 64 primes
    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic sha_word_t sha256_ssig0(input sha_word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic sha_word_t sha256_ssig1(input sha_word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic sha_word_t sha256_bsig0(input sha_word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic sha_word_t sha256_bsig1(input sha_word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup: 6-bit round index to K[t].
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx,
    output logic [31:0] k
);

    assign k = SHA256_K[idx];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[t]/K[t] for t = 0..ROUNDS-1.
// state | meaning: LOAD = accepting W[0..15] into the buffer; RUN = emitting schedule words.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        clr_i,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    input  logic [31:0] w_data_bi,
    output logic        sch_valid_o,
    input  logic        sch_ready_i,
    output logic [31:0] sch_w_bo,
    output logic [31:0] sch_k_bo,
    output logic [5:0]  sch_idx_bo,
    output logic        sch_last_o,
    output logic        busy_o
);

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_t state;
    logic [3:0]   cnt;
    logic [5:0]   t;
    sha_word_t    wbuf [16];

    logic         w_hs;
    logic         s_hs;
    logic [3:0]   t4;
    logic [3:0]   tm2;
    logic [3:0]   tm7;
    logic [3:0]   tm15;
    sha_word_t    w_next;
    sha_word_t    w_cur;
    logic [31:0]  k_raw;

    assign w_ready_o   = (state == LOAD);
    assign sch_valid_o = (state == RUN);
    assign busy_o      = sch_valid_o;

    assign w_hs = w_valid_i & w_ready_o;
    assign s_hs = sch_valid_o & sch_ready_i;

    // 4-bit wrap of the subtraction gives the mod-16 buffer address directly
    assign t4   = t[3:0];
    assign tm2  = t4 - 4'd2;
    assign tm7  = t4 - 4'd7;
    assign tm15 = t4 - 4'd15;

    assign w_next = sha256_ssig1(wbuf[tm2]) + wbuf[tm7] + sha256_ssig0(wbuf[tm15]) + wbuf[t4];
    assign w_cur  = (t < 6'd16) ? wbuf[t4] : w_next;

    sha256_k_rom u_k_rom (
        .idx (t),
        .k   (k_raw)
    );

    assign sch_w_bo   = sch_valid_o ? w_cur : '0;
    assign sch_k_bo   = sch_valid_o ? k_raw : '0;
    assign sch_idx_bo = sch_valid_o ? t : '0;
    assign sch_last_o = sch_valid_o && (t == LAST_T);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= LOAD;
            cnt   <= '0;
            t     <= '0;
            for (int i = 0; i < 16; i++) begin
                wbuf[i] <= '0;
            end
        end else if (clr_i) begin
            state <= LOAD;
            cnt   <= '0;
            t     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (w_hs) begin
                        wbuf[cnt] <= w_data_bi;
                        cnt       <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            state <= RUN;
                            t     <= '0;
                        end
                    end
                end
                RUN: begin
                    if (s_hs) begin
                        // W[t] replaces W[t-16], which no later round needs
                        if (t >= 6'd16) begin
                            wbuf[t4] <= w_next;
                        end
                        if (t == LAST_T) begin
                            state <= LOAD;
                            cnt   <= '0;
                            t     <= '0;
                        end else begin
                            t <= t + 6'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched against a whole-array schedule model.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        arst;
    logic        clr;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic        sch_valid;
    logic        sch_ready;
    logic [31:0] sch_w;
    logic [31:0] sch_k;
    logic [5:0]  sch_idx;
    logic        sch_last;
    logic        busy;

    logic        r_clr;
    logic        r_w_valid;
    logic        r_w_ready;
    logic [31:0] r_w_data;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_w;
    logic [31:0] r_k;
    logic [5:0]  r_idx;
    logic        r_last;
    logic        r_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] blk   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    logic [31:0] kt [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    always #5 clk = ~clk;

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .clr_i       (clr),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .w_data_bi   (w_data),
        .sch_valid_o (sch_valid),
        .sch_ready_i (sch_ready),
        .sch_w_bo    (sch_w),
        .sch_k_bo    (sch_k),
        .sch_idx_bo  (sch_idx),
        .sch_last_o  (sch_last),
        .busy_o      (busy)
    );

    sha256_msg_sched #(.ROUNDS(16)) dut16 (
        .clk_i       (clk),
        .arst_i      (arst),
        .clr_i       (r_clr),
        .w_valid_i   (r_w_valid),
        .w_ready_o   (r_w_ready),
        .w_data_bi   (r_w_data),
        .sch_valid_o (r_valid),
        .sch_ready_i (r_ready),
        .sch_w_bo    (r_w),
        .sch_k_bo    (r_k),
        .sch_idx_bo  (r_idx),
        .sch_last_o  (r_last),
        .busy_o      (r_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Model: plain recurrence over the full 64-entry schedule array
    task automatic build_model();
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                exp_w[i] = blk[i];
            end else begin
                exp_w[i] = (rotr(exp_w[i-2], 17) ^ rotr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                         + exp_w[i-7]
                         + (rotr(exp_w[i-15], 7) ^ rotr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                         + exp_w[i-16];
            end
        end
    endtask

    task automatic gen_block();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        build_model();
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_wready"}, 32'(w_ready), 32'd1);
        check_val({tag, "_valid"},  32'(sch_valid), 32'd0);
        check_val({tag, "_busy"},   32'(busy), 32'd0);
        check_val({tag, "_w"},      sch_w, 32'd0);
        check_val({tag, "_k"},      sch_k, 32'd0);
        check_val({tag, "_idx"},    32'(sch_idx), 32'd0);
        check_val({tag, "_last"},   32'(sch_last), 32'd0);
    endtask

    // Entered and left at a negedge; nwords < 16 leaves the block partially loaded
    task automatic load_block(input int nwords);
        int  n = 0;
        int  cyc = 0;
        logic hs;
        sch_ready = 1'b0;
        while (n < nwords && cyc < 200) begin
            cyc++;
            check_val("load_valid_low", 32'(sch_valid), 32'd0);
            w_valid = ($urandom_range(3) != 0);
            w_data  = blk[n];
            hs = w_valid & w_ready;
            @(posedge clk);
            @(negedge clk);
            if (hs) n++;
        end
        w_valid = 1'b0;
        if (n < nwords) check_val("load_timeout", 32'(n), 32'(nwords));
        if (nwords == 16) begin
            check_val("run_valid", 32'(sch_valid), 32'd1);
            check_val("run_busy",  32'(busy), 32'd1);
            check_val("run_wready", 32'(w_ready), 32'd0);
        end
    endtask

    // stop_kind: 0 = run to the end, 1 = clr at stop_at, 2 = arst pulse at stop_at
    task automatic run_block(input int stall_pct, input int stop_kind, input int stop_at);
        int   t_exp = 0;
        int   cyc = 0;
        bit   done = 0;
        logic rdy;
        while (!done && cyc < 2000) begin
            cyc++;
            check_val("sch_valid", 32'(sch_valid), 32'd1);
            check_val($sformatf("idx[%0d]", t_exp), 32'(sch_idx), 32'(t_exp));
            check_val($sformatf("w[%0d]", t_exp), sch_w, exp_w[t_exp]);
            check_val($sformatf("k[%0d]", t_exp), sch_k, kt[t_exp]);
            check_val($sformatf("last[%0d]", t_exp), 32'(sch_last), 32'(t_exp == 63));
            got_w[t_exp] = sch_w;
            if (stop_kind == 1 && t_exp == stop_at) begin
                clr = 1'b1;
                sch_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                clr = 1'b0;
                sch_ready = 1'b0;
                check_idle("after_clr");
                done = 1;
            end else if (stop_kind == 2 && t_exp == stop_at) begin
                arst = 1'b1;
                #1;
                check_idle("arst_run");
                #1 arst = 1'b0;
                sch_ready = 1'b0;
                @(negedge clk);
                done = 1;
            end else begin
                sch_ready = ($urandom_range(99) >= stall_pct);
                w_valid = $urandom_range(1);
                w_data = $urandom;
                rdy = sch_ready;
                @(posedge clk);
                @(negedge clk);
                if (rdy) begin
                    if (t_exp == 63) done = 1;
                    else t_exp++;
                end
            end
        end
        w_valid = 1'b0;
        sch_ready = 1'b0;
        if (!done) check_val("run_timeout", 32'(t_exp), 32'd63);
        else if (stop_kind == 0) check_idle("after_last");
    endtask

    initial begin
        arst = 1'b1;
        clr = 1'b0;
        w_valid = 1'b0;
        w_data = '0;
        sch_ready = 1'b0;
        r_clr = 1'b0;
        r_w_valid = 1'b0;
        r_w_data = '0;
        r_ready = 1'b0;

        @(negedge clk);
        check_idle("reset");
        check_val("reset16_wready", 32'(r_w_ready), 32'd1);
        check_val("reset16_valid", 32'(r_valid), 32'd0);
        arst = 1'b0;
        @(negedge clk);

        // "abc" padded block
        for (int i = 0; i < 16; i++) blk[i] = 32'd0;
        blk[0] = 32'h61626380;
        blk[15] = 32'h00000018;
        build_model();
        load_block(16);
        run_block(0, 0, 0);
        check_val("abc_w16", got_w[16], 32'h61626380);
        check_val("abc_w17", got_w[17], 32'h000F0000);

        // Same block under random stalls, then a random block back-to-back
        load_block(16);
        run_block(50, 0, 0);
        gen_block();
        load_block(16);
        run_block(30, 0, 0);

        // clr mid-run, clr during load with a coincident word, then a fresh block
        gen_block();
        load_block(16);
        run_block(0, 1, 30);
        gen_block();
        load_block(5);
        clr = 1'b1;
        w_valid = 1'b1;
        w_data = $urandom;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        w_valid = 1'b0;
        check_val("clr_load_wready", 32'(w_ready), 32'd1);
        gen_block();
        load_block(16);
        run_block(20, 0, 0);

        // Asynchronous reset mid-load (7 words), then a full block
        gen_block();
        load_block(7);
        arst = 1'b1;
        #1;
        check_idle("arst_load");
        #1 arst = 1'b0;
        @(negedge clk);
        gen_block();
        load_block(16);
        run_block(0, 0, 0);

        // Asynchronous reset mid-run (t=40), then a full block
        gen_block();
        load_block(16);
        run_block(20, 2, 40);
        gen_block();
        load_block(16);
        run_block(40, 0, 0);

        // ROUNDS=16 instance: exactly the 16 input words come back
        gen_block();
        for (int n = 0; n < 16; n++) begin
            check_val("r16_wready", 32'(r_w_ready), 32'd1);
            r_w_valid = 1'b1;
            r_w_data = blk[n];
            @(posedge clk);
            @(negedge clk);
        end
        r_w_valid = 1'b0;
        for (int t = 0; t < 16; t++) begin
            check_val("r16_valid", 32'(r_valid), 32'd1);
            check_val($sformatf("r16_idx[%0d]", t), 32'(r_idx), 32'(t));
            check_val($sformatf("r16_w[%0d]", t), r_w, blk[t]);
            check_val($sformatf("r16_k[%0d]", t), r_k, kt[t]);
            check_val($sformatf("r16_last[%0d]", t), 32'(r_last), 32'(t == 15));
            r_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        r_ready = 1'b0;
        check_val("r16_done_valid", 32'(r_valid), 32'd0);
        check_val("r16_done_wready", 32'(r_w_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
